// File: rtl/pitch_env_mc_if.sv
// pitch_env_mc_if: control/result bundle between the voice allocator and pitch_env_mc
// Signals (per channel c, packed little-endian by channel index):
//   en           global clock enable
//   speed        global rate, timer increment = 2^speed
//   mode         2 bits per channel: 00 bypass, 01 fall, 10 rise, 11 scoop
//   note_on      gate per channel
//   note_repeat  retrigger pulse per channel for a repeated identical note
//   note         7-bit MIDI note per channel
//   offset       signed AMT_W+1 bit semitone offset per channel
//   active       high while the channel is ramping
// Modports: master drives the controls, slave (the envelope block) drives the results.
interface pitch_env_mc_if #(
    parameter int NUM_CH = 4,
    parameter int AMT_W  = 7
);
    logic                          en;
    logic [3:0]                    speed;
    logic [2*NUM_CH-1:0]           mode;
    logic [NUM_CH-1:0]             note_on;
    logic [NUM_CH-1:0]             note_repeat;
    logic [7*NUM_CH-1:0]           note;
    logic [(AMT_W+1)*NUM_CH-1:0]   offset;
    logic [NUM_CH-1:0]             active;

    modport master (
        output en, speed, mode, note_on, note_repeat, note,
        input  offset, active
    );

    modport slave (
        input  en, speed, mode, note_on, note_repeat, note,
        output offset, active
    );
endinterface

// File: rtl/pitch_env_mc.sv
// pitch_env_mc: multi-channel pitch envelope generator with fall / rise / scoop ramps
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      pitch_env_mc_if.slave; inputs en, speed, mode, note_on, note_repeat, note;
//            outputs offset (registered, signed, AMT_W+1 bits per channel) and active
module pitch_env_mc #(
    parameter int NUM_CH  = 4,
    parameter int AMT_W   = 7,
    parameter int MAX_AMT = 24,
    parameter int TIMER_W = 26,
    parameter int THRESH  = 2097120
) (
    input logic           clk,
    input logic           reset_n,
    pitch_env_mc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [TIMER_W-1:0]    THR   = TIMER_W'(THRESH);
    localparam logic [TIMER_W-1:0]    T_ONE = TIMER_W'(1);
    localparam logic [AMT_W-1:0]      MAX_S = AMT_W'(MAX_AMT);
    localparam logic signed [AMT_W:0] MAX_O = (AMT_W+1)'(MAX_AMT);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t                state_q, state_d;
        logic [6:0]            note_lat_q, note_lat_d;
        logic [1:0]            mode_lat_q, mode_lat_d;
        logic                  gate_hist_q, gate_hist_d;
        logic [AMT_W-1:0]      step_q, step_d;
        logic [TIMER_W-1:0]    timer_q, timer_d;
        logic signed [AMT_W:0] offset_q, offset_d, step_s;
        logic                  on, rep, trig;
        logic [6:0]            note_in;
        logic [1:0]            mode_in;

        assign on      = bus.note_on[c];
        assign rep     = bus.note_repeat[c];
        assign note_in = bus.note[7*c +: 7];
        assign mode_in = bus.mode[2*c +: 2];

        // A new or repeated note, or a fresh gate, restarts the ramp.
        assign trig = on & (~gate_hist_q | (note_in != note_lat_q) | rep);

        always_comb begin
            state_d     = state_q;
            note_lat_d  = note_lat_q;
            mode_lat_d  = mode_lat_q;
            gate_hist_d = gate_hist_q;
            step_d      = step_q;
            timer_d     = timer_q;
            if (bus.en) begin
                gate_hist_d = on;
                if (!on) begin
                    state_d    = IDLE;
                    note_lat_d = '0;
                end else if (trig) begin
                    state_d    = (mode_in == 2'b00) ? HOLD : RUN;
                    note_lat_d = note_in;
                    mode_lat_d = mode_in;
                    step_d     = '0;
                    timer_d    = T_ONE;
                end else if (state_q == RUN) begin
                    if (timer_q > THR) begin
                        step_d  = step_q + AMT_W'(1);
                        timer_d = T_ONE;
                        state_d = (step_d == MAX_S) ? HOLD : RUN;
                    end else begin
                        timer_d = timer_q + (T_ONE << bus.speed);
                    end
                end
            end
            // Offset tracks the next step/mode so it is valid right after each change;
            // entering IDLE leaves the last value in place as a release tail.
            step_s   = {1'b0, step_d};
            offset_d = (!bus.en || state_d == IDLE) ? offset_q :
                       (mode_lat_d == 2'b01)        ? -step_s :
                       (mode_lat_d == 2'b10)        ? step_s :
                       (mode_lat_d == 2'b11)        ? step_s - MAX_O : '0;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q     <= IDLE;
                note_lat_q  <= '0;
                mode_lat_q  <= '0;
                gate_hist_q <= 1'b0;
                step_q      <= '0;
                timer_q     <= T_ONE;
                offset_q    <= '0;
            end else begin
                state_q     <= state_d;
                note_lat_q  <= note_lat_d;
                mode_lat_q  <= mode_lat_d;
                gate_hist_q <= gate_hist_d;
                step_q      <= step_d;
                timer_q     <= timer_d;
                offset_q    <= offset_d;
            end
        end

        assign bus.offset[(AMT_W+1)*c +: AMT_W+1] = offset_q;
        assign bus.active[c]                      = (state_q == RUN);
    end
endmodule

// File: tb/tb_pitch_env_mc.sv
// tb_pitch_env_mc: table vectors, directed corner sequences and a randomized run against a step-count model
module tb_pitch_env_mc;
    localparam int NUM_CH  = 4;
    localparam int AMT_W   = 7;
    localparam int MAX_AMT = 24;
    localparam int THRESH  = 2097120;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pitch_env_mc_if #(.NUM_CH(NUM_CH), .AMT_W(AMT_W)) bus ();

    pitch_env_mc #(
        .NUM_CH(NUM_CH), .AMT_W(AMT_W), .MAX_AMT(MAX_AMT), .TIMER_W(26), .THRESH(THRESH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        int         ch;
        logic [1:0] mode;
        int         spd;
        int         n;
        int         exp_off;
        int         exp_act;
    } vec_t;
    vec_t vt[$];

    bit         m_gate[NUM_CH];
    bit         m_live[NUM_CH];
    int         m_n[NUM_CH];
    logic [6:0] m_note[NUM_CH];
    logic [1:0] m_mode[NUM_CH];
    int         m_off[NUM_CH];
    int         m_act[NUM_CH];

    function automatic int off_of(int ch);
        return int'($signed(bus.offset[(AMT_W+1)*ch +: AMT_W+1]));
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n          = 1'b0;
        bus.en           = 1'b1;
        bus.speed        = 4'd15;
        bus.mode         = '0;
        bus.note_on      = '0;
        bus.note_repeat  = '0;
        bus.note         = {NUM_CH{7'd60}};
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic model_init();
        for (int c = 0; c < NUM_CH; c++) begin
            m_gate[c] = 0; m_live[c] = 0; m_n[c] = 0;
            m_note[c] = '0; m_mode[c] = '0; m_off[c] = 0; m_act[c] = 0;
        end
    endtask

    // One clock with the currently driven inputs; the model counts enabled
    // cycles since the trigger and derives the step as n / period.
    task automatic cyc_chk();
        bit en_s;
        logic [NUM_CH-1:0] on_s, rep_s;
        logic [7*NUM_CH-1:0] nt_s;
        logic [2*NUM_CH-1:0] md_s;
        int p, st;
        en_s  = bus.en;
        on_s  = bus.note_on;
        rep_s = bus.note_repeat;
        nt_s  = bus.note;
        md_s  = bus.mode;
        p = (THRESH + (1 << bus.speed) - 1) / (1 << bus.speed) + 1;
        @(negedge clk);
        if (en_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!on_s[c]) begin
                    m_live[c] = 0;
                    m_note[c] = '0;
                end else if (!m_gate[c] || nt_s[7*c +: 7] != m_note[c] || rep_s[c]) begin
                    m_live[c] = 1;
                    m_n[c]    = 0;
                    m_mode[c] = md_s[2*c +: 2];
                    m_note[c] = nt_s[7*c +: 7];
                end else if (m_live[c]) begin
                    m_n[c]++;
                end
                m_gate[c] = on_s[c];
                if (m_live[c]) begin
                    st = m_n[c] / p;
                    if (st > MAX_AMT) st = MAX_AMT;
                    m_off[c] = (m_mode[c] == 2'b01) ? -st :
                               (m_mode[c] == 2'b10) ? st :
                               (m_mode[c] == 2'b11) ? st - MAX_AMT : 0;
                    m_act[c] = (m_mode[c] != 2'b00 && st < MAX_AMT) ? 1 : 0;
                end else begin
                    m_act[c] = 0;
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("rand ch%0d off", c), off_of(c), m_off[c]);
            check($sformatf("rand ch%0d act", c), int'(bus.active[c]), m_act[c]);
        end
    endtask

    initial begin
        int spds[5] = '{15, 14, 15, 13, 15};

        vt.push_back('{0, 2'b01, 15,    0,   0, 1});
        vt.push_back('{0, 2'b01, 15,   64,   0, 1});
        vt.push_back('{0, 2'b01, 15,   65,  -1, 1});
        vt.push_back('{0, 2'b01, 15, 1559, -23, 1});
        vt.push_back('{0, 2'b01, 15, 1560, -24, 0});
        vt.push_back('{1, 2'b11, 15,    0, -24, 1});
        vt.push_back('{1, 2'b11, 15,   65, -23, 1});
        vt.push_back('{1, 2'b11, 15, 1560,   0, 0});
        vt.push_back('{2, 2'b10, 15,  130,   2, 1});
        vt.push_back('{2, 2'b10, 15, 1560,  24, 0});
        vt.push_back('{3, 2'b00, 15,    0,   0, 0});
        vt.push_back('{3, 2'b00, 15,  300,   0, 0});
        vt.push_back('{0, 2'b01, 14,  128,   0, 1});
        vt.push_back('{0, 2'b01, 14,  129,  -1, 1});
        vt.push_back('{0, 2'b01, 13,  257,  -1, 1});

        do_reset();
        check("reset offsets", int'(bus.offset != '0), 0);
        check("reset active", int'(bus.active), 0);
        tick(3);
        check("idle offsets", int'(bus.offset != '0), 0);

        foreach (vt[i]) begin
            do_reset();
            bus.speed = 4'(vt[i].spd);
            bus.mode[2*vt[i].ch +: 2] = vt[i].mode;
            bus.note_on[vt[i].ch] = 1'b1;
            tick(1);
            tick(vt[i].n);
            check($sformatf("vec%0d off", i), off_of(vt[i].ch), vt[i].exp_off);
            check($sformatf("vec%0d act", i), int'(bus.active[vt[i].ch]), vt[i].exp_act);
        end

        // Note change mid-ramp restarts, then retrigger from HOLD via note_repeat.
        do_reset();
        bus.mode[1:0] = 2'b01;
        bus.note_on[0] = 1'b1;
        tick(1);
        tick(325);
        check("nc step5", off_of(0), -5);
        bus.note[6:0] = 7'd62;
        tick(1);
        check("nc restart off", off_of(0), 0);
        check("nc restart act", int'(bus.active[0]), 1);
        tick(64);
        check("nc +64", off_of(0), 0);
        tick(1);
        check("nc +65", off_of(0), -1);
        tick(1495);
        check("hold off", off_of(0), -24);
        check("hold act", int'(bus.active[0]), 0);
        bus.note_repeat[0] = 1'b1;
        tick(1);
        bus.note_repeat[0] = 1'b0;
        check("repeat off", off_of(0), 0);
        check("repeat act", int'(bus.active[0]), 1);
        tick(195);
        check("repeat step3", off_of(0), -3);
        bus.note_on[0] = 1'b0;
        tick(1);
        check("release off", off_of(0), -3);
        check("release act", int'(bus.active[0]), 0);
        bus.note_repeat[0] = 1'b1;
        tick(1);
        bus.note_repeat[0] = 1'b0;
        check("rep gated off", off_of(0), -3);
        check("rep gated act", int'(bus.active[0]), 0);
        bus.note_on[0] = 1'b1;
        tick(1);
        check("repress off", off_of(0), 0);
        check("repress act", int'(bus.active[0]), 1);

        // Release at step 7 keeps the tail value.
        do_reset();
        bus.mode[1:0] = 2'b01;
        bus.note_on[0] = 1'b1;
        tick(1);
        tick(455);
        check("rel7 pre", off_of(0), -7);
        bus.note_on[0] = 1'b0;
        tick(1);
        check("rel7 off", off_of(0), -7);
        check("rel7 act", int'(bus.active[0]), 0);

        // Enable low freezes everything; the ramp resumes on the same count.
        do_reset();
        bus.mode[1:0] = 2'b01;
        bus.note_on[0] = 1'b1;
        tick(1);
        tick(100);
        check("en pre", off_of(0), -1);
        bus.en = 1'b0;
        tick(100);
        check("en frozen off", off_of(0), -1);
        check("en frozen act", int'(bus.active[0]), 1);
        bus.en = 1'b1;
        tick(29);
        check("en resume 129", off_of(0), -1);
        tick(1);
        check("en resume 130", off_of(0), -2);

        // Asynchronous reset mid-run on all channels.
        do_reset();
        bus.mode = 8'b01_11_10_01;
        bus.note_on = '1;
        tick(1);
        tick(200);
        check("ar ch1 pre", off_of(1), 3);
        check("ar ch2 pre", off_of(2), -21);
        #2 reset_n = 1'b0;
        #1;
        check("ar offsets", int'(bus.offset != '0), 0);
        check("ar active", int'(bus.active), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized run: speed fixed per segment, all gates dropped between segments.
        do_reset();
        model_init();
        for (int s = 0; s < 5; s++) begin
            bus.note_on = '0;
            bus.note_repeat = '0;
            bus.en = 1'b1;
            cyc_chk();
            bus.speed = 4'(spds[s]);
            repeat (4000) begin
                bus.en = ($urandom_range(0, 9) != 0);
                for (int c = 0; c < NUM_CH; c++) begin
                    if (bus.note_on[c]) begin
                        if ($urandom_range(0, 1499) == 0) bus.note_on[c] = 1'b0;
                    end else if ($urandom_range(0, 19) == 0) begin
                        bus.note_on[c] = 1'b1;
                    end
                    if ($urandom_range(0, 699) == 0) bus.note[7*c +: 7] = 7'(60 + 2 * $urandom_range(0, 2));
                    bus.note_repeat[c] = ($urandom_range(0, 899) == 0);
                    bus.mode[2*c +: 2] = 2'($urandom_range(0, 3));
                end
                cyc_chk();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
